// File: rtl/router_pkg.sv
// Shared sizing and entry layout for the router FIFO slice.
package router_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PTR_W      = 5;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned ADDR_W     = PTR_W - 1;
  localparam int unsigned ENTRY_W    = DATA_W + 1;

  typedef struct packed {
    logic              lfd;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_fifo_ram.sv
// 16x9 storage: one synchronous write port, one asynchronous read port, no reset.
module router_fifo_ram
  import router_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data_c
);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-port router FIFO: 16 header-tagged bytes, packet-length tracking on read.
module router_fifo
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   pkt_count;
  logic               do_write;
  logic               do_read;
  logic [ENTRY_W-1:0] rd_word;
  fifo_entry_t        wr_entry;
  fifo_entry_t        rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  // Flags are sampled before the edge; a flush cycle suppresses both ports.
  assign do_write = write_enb && !full  && !soft_reset;
  assign do_read  = read_enb  && !empty && !soft_reset;

  assign wr_entry = '{lfd: lfd_state, data: data_in};
  assign rd_entry = fifo_entry_t'(rd_word);

  router_fifo_ram u_ram (
    .clk       (clk),
    .wr_en     (do_write),
    .wr_addr   (wr_ptr[ADDR_W-1:0]),
    .wr_data   (ENTRY_W'(wr_entry)),
    .rd_addr   (rd_ptr[ADDR_W-1:0]),
    .rd_data_c (rd_word)
  );

  // Pointer update; the extra wrap bit distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Read data and remaining-packet count; data_out returns to zero once a packet is done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      pkt_count <= '0;
    end else if (soft_reset) begin
      data_out  <= '0;
      pkt_count <= '0;
    end else if (do_read) begin
      data_out <= rd_entry.data;
      if (rd_entry.lfd) begin
        pkt_count <= CNT_W'(rd_entry.data[DATA_W-1:2]) + CNT_W'(1);
      end else if (pkt_count != '0) begin
        pkt_count <= pkt_count - CNT_W'(1);
      end
    end else if (pkt_count == '0) begin
      data_out <= '0;
    end
  end

endmodule
